// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - runtime-programmable integer clock divider with tick enable
// Optional half-cycle odd-divisor duty correction: CLK_DIV_ODD_DUTY50_EN
module clk_div_prog #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic [CNT_W-1:0] div_active,
  output logic             div_pending
);

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] pend_val;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] last_cnt;
  logic [CNT_W-1:0] high_last;
  logic             boundary;
  logic             pos_q;

  always_comb begin
    load_val  = (div_val < TWO) ? TWO : div_val;
    last_cnt  = div_active - ONE;
    high_last = (div_active >> 1) - ONE;
    boundary  = en && (cnt == last_cnt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= DEF_DIV - ONE;
      pos_q       <= 1'b0;
      tick        <= 1'b0;
      div_active  <= DEF_DIV;
      div_pending <= 1'b0;
      pend_val    <= DEF_DIV;
    end else if (boundary) begin
      cnt   <= '0;
      pos_q <= 1'b1;
      tick  <= 1'b1;
      // A load landing on the boundary bypasses the pending register.
      if (div_load) begin
        div_active  <= load_val;
        div_pending <= 1'b0;
      end else if (div_pending) begin
        div_active  <= pend_val;
        div_pending <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
      if (div_load) begin
        pend_val    <= load_val;
        div_pending <= 1'b1;
      end
      if (en) begin
        cnt <= cnt + ONE;
        if (cnt == high_last) pos_q <= 1'b0;
      end
    end
  end

`ifdef CLK_DIV_ODD_DUTY50_EN
  logic neg_q;

  // Half-cycle delayed copy stretches the high phase only for odd divisors.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) neg_q <= 1'b0;
    else        neg_q <= div_active[0] & pos_q;
  end

  assign clk_out = pos_q | neg_q;
`else
  assign clk_out = pos_q;
`endif

endmodule
